imem_loader: RTL

Boot-time program loader and the write side of instruction memory, which the core only ever reads. It accepts a byte stream over a valid/ready handshake, assembles little-endian 32-bit words and writes them into imem at consecutive word addresses. It holds the core in reset until a complete, checksum-verified image has been written.

---
 rtl/imem_loader_if.sv | 30 +++
 rtl/imem_loader.sv | 106 ++++++++++
 2 files changed

// File: rtl/imem_loader_if.sv
// Byte-stream receive handshake and imem write bus for the boot loader.
// master = loader side, slave = stream source / memory side.
interface imem_loader_if #(
    parameter int ADDR_W = 6
);
    logic              rx_valid;
    logic [7:0]        rx_data;
    logic              rx_ready;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wd;

    modport master (
        input  rx_valid,
        input  rx_data,
        output rx_ready,
        output imem_we,
        output imem_addr,
        output imem_wd
    );

    modport slave (
        output rx_valid,
        output rx_data,
        input  rx_ready,
        input  imem_we,
        input  imem_addr,
        input  imem_wd
    );
endinterface

// File: rtl/imem_loader.sv
// Boot loader: receives a length/payload/checksum byte frame, writes imem,
// and releases core reset only after a verified image has been stored.
module imem_loader #(
    parameter int DEPTH  = 64,
    parameter int ADDR_W = 6
) (
    input  logic         clk,
    input  logic         reset,
    imem_loader_if.master bus,
    output logic         core_reset,
    output logic         done,
    output logic         error
);
    typedef enum logic [2:0] {
        S_LEN,
        S_DATA,
        S_CSUM,
        S_DONE,
        S_ERR
    } state_t;

    localparam logic [31:0]     DEPTH_W = 32'(DEPTH);
    localparam logic [ADDR_W:0] WONE    = 1;

    state_t          state;
    logic            armed;
    logic [31:0]     len_q;
    logic [31:0]     asm_q;
    logic [1:0]      bcnt;
    logic [ADDR_W:0] widx;
    logic [7:0]      xsum;

    logic            accept;
    logic [31:0]     len_nxt;
    logic [31:0]     word_nxt;
    logic [ADDR_W:0] widx_nxt;

    // Bytes arrive LSB first, so each new byte enters at the top.
    assign accept   = bus.rx_valid && bus.rx_ready;
    assign len_nxt  = {bus.rx_data, len_q[31:8]};
    assign word_nxt = {bus.rx_data, asm_q[31:8]};
    assign widx_nxt = widx + WONE;

    // Status decoded straight from the state register.
    assign bus.rx_ready = armed &&
        (state == S_LEN || state == S_DATA || state == S_CSUM);
    assign core_reset = (state != S_DONE);
    assign done       = (state == S_DONE);
    assign error      = (state == S_ERR);

    // Frame FSM, byte assembly and registered imem write port.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= S_LEN;
            armed         <= 1'b0;
            len_q         <= '0;
            asm_q         <= '0;
            bcnt          <= '0;
            widx          <= '0;
            xsum          <= '0;
            bus.imem_we   <= 1'b0;
            bus.imem_addr <= '0;
            bus.imem_wd   <= '0;
        end else begin
            armed       <= 1'b1;
            bus.imem_we <= 1'b0;
            if (accept) begin
                xsum <= xsum ^ bus.rx_data;
                case (state)
                    S_LEN: begin
                        len_q <= len_nxt;
                        bcnt  <= bcnt + 2'd1;
                        if (bcnt == 2'd3) begin
                            if (len_nxt > DEPTH_W)
                                state <= S_ERR;
                            else if (len_nxt == '0)
                                state <= S_CSUM;
                            else
                                state <= S_DATA;
                        end
                    end
                    S_DATA: begin
                        asm_q <= word_nxt;
                        bcnt  <= bcnt + 2'd1;
                        if (bcnt == 2'd3) begin
                            bus.imem_we   <= 1'b1;
                            bus.imem_addr <= widx[ADDR_W-1:0];
                            bus.imem_wd   <= word_nxt;
                            widx          <= widx_nxt;
                            if ({{(31-ADDR_W){1'b0}}, widx_nxt} == len_q)
                                state <= S_CSUM;
                        end
                    end
                    S_CSUM: begin
                        if (bus.rx_data == xsum)
                            state <= S_DONE;
                        else
                            state <= S_ERR;
                    end
                    default: begin
                    end
                endcase
            end
        end
    end
endmodule
